// File: rtl/l2c_wb_arb_pkg.sv
// Shared definitions for the L2C writeback arbiter: line/ack-FIFO sizing,
// requester ID width, FSM state encoding and the forwarded beat payload.
package l2c_wb_arb_pkg;

    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned ACK_DEPTH  = 8;
    localparam int unsigned ID_W       = 1;
    localparam int unsigned BEAT_W     = $clog2(LINE_WORDS);
    localparam int unsigned ACK_CNT_W  = $clog2(ACK_DEPTH) + 1;

    // One-hot arbiter states
    typedef enum logic [2:0] {
        ARB_IDLE = 3'b001,
        BUSY0    = 3'b010,
        BUSY1    = 3'b100
    } arb_state_e;

    // One writeback beat as forwarded to the L2C
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } wb_beat_t;

endpackage

// File: rtl/wb_id_fifo.sv
// Synchronous FIFO of requester IDs, one entry per issued-but-unacked line.
// Ports: clk, rst (sync active-high), push/din, pop/dout (head, show-ahead),
// empty, count (number of stored entries).
module wb_id_fifo
    import l2c_wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = ACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ID_W-1:0]        din,
    output logic [ID_W-1:0]        dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guards keep pointers sane even if a caller misbehaves
    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/l2c_wb_arb.sv
// Two-requester arbiter for the L2C writeback port. Grants whole lines
// round-robin, forwards the granted requester's beats with one cycle of
// latency, and routes each L2C ack back to the line's issuer in issue order.
// Ports: requester 0/1 req/space/beat inputs and ack outputs with stall,
// L2C beat outputs and ack inputs with stall, sticky protocol error o_err.
module l2c_wb_arb
    import l2c_wb_arb_pkg::*;
(
    input  logic        clk_mc,
    input  logic        rst_mc,
    input  logic        i_req0_req,
    input  logic        i_req1_req,
    output logic        o_req0_space,
    output logic        o_req1_space,
    input  logic        i_req0_valid,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req0_adr,
    input  logic [31:0] i_req1_adr,
    input  logic [31:0] i_req0_data,
    input  logic [31:0] i_req1_data,
    input  logic        i_l2c_wb_space,
    output logic        o_l2c_wb_valid,
    output logic [31:0] o_l2c_wb_adr,
    output logic [31:0] o_l2c_wb_data,
    input  logic        i_l2c_wb_ack_valid,
    input  logic        i_l2c_wb_ack_fault,
    input  logic [31:0] i_l2c_wb_ack_adr,
    output logic        o_l2c_wb_ack_stall,
    output logic        o_req0_ack_valid,
    output logic        o_req1_ack_valid,
    output logic        o_req0_ack_fault,
    output logic        o_req1_ack_fault,
    output logic [31:0] o_req0_ack_adr,
    output logic [31:0] o_req1_ack_adr,
    input  logic        i_req0_ack_stall,
    input  logic        i_req1_ack_stall,
    output logic        o_err
);

    arb_state_e           state_q, state_d;
    logic                 rr_q, rr_d;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic                 beat_vld_q, beat_vld_d;
    wb_beat_t             beat_q, beat_d;
    logic                 err_q, err_d;

    logic                 push;
    logic [ID_W-1:0]      push_id;
    logic                 pop;
    logic [ID_W-1:0]      fifo_dout;
    logic                 fifo_empty;
    logic [ACK_CNT_W-1:0] fifo_count;
    logic                 head;
    logic                 grant_ok;
    logic                 own_valid;
    logic                 other_valid;
    logic [31:0]          own_adr;
    logic [31:0]          own_data;

    wb_id_fifo #(.DEPTH(ACK_DEPTH)) u_id_fifo (
        .clk   (clk_mc),
        .rst   (rst_mc),
        .push  (push),
        .pop   (pop),
        .din   (push_id),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Granting only with FIFO room guarantees every completed line can be pushed
    assign grant_ok = i_l2c_wb_space && (i_req0_req || i_req1_req)
                      && (fifo_count < ACK_CNT_W'(ACK_DEPTH));

    // Beat source selection by current owner
    assign own_valid   = (state_q == BUSY1) ? i_req1_valid : i_req0_valid;
    assign other_valid = (state_q == BUSY1) ? i_req0_valid : i_req1_valid;
    assign own_adr     = (state_q == BUSY1) ? i_req1_adr   : i_req0_adr;
    assign own_data    = (state_q == BUSY1) ? i_req1_data  : i_req0_data;

    // Next state, round-robin pointer, beat counter, forwarded beat, error
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_id    = '0;
        beat_vld_d = 1'b0;
        beat_d     = beat_q;
        err_d      = err_q;

        if (i_l2c_wb_ack_valid && fifo_empty) begin
            err_d = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    err_d = 1'b1;
                end
                if (grant_ok) begin
                    if (i_req0_req && (!i_req1_req || !rr_q)) begin
                        state_d = BUSY0;
                        rr_d    = 1'b1;
                    end else begin
                        state_d = BUSY1;
                        rr_d    = 1'b0;
                    end
                end
            end
            BUSY0, BUSY1: begin
                if (other_valid) begin
                    err_d = 1'b1;
                end
                if (own_valid) begin
                    beat_vld_d  = 1'b1;
                    beat_d.adr  = own_adr;
                    beat_d.data = own_data;
                    cnt_d       = cnt_q + BEAT_W'(1);
                    if (cnt_q == BEAT_W'(LINE_WORDS - 1)) begin
                        push    = 1'b1;
                        push_id = ID_W'(state_q == BUSY1);
                        cnt_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_mc) begin
        if (rst_mc) begin
            state_q    <= ARB_IDLE;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            beat_vld_q <= 1'b0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            beat_vld_q <= beat_vld_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
        end
    end

    // Grants are the one-hot state bits themselves
    assign o_req0_space   = (state_q == BUSY0);
    assign o_req1_space   = (state_q == BUSY1);
    assign o_l2c_wb_valid = beat_vld_q;
    assign o_l2c_wb_adr   = beat_q.adr;
    assign o_l2c_wb_data  = beat_q.data;
    assign o_err          = err_q;

    // Zero-latency ack routing from the FIFO head; fault/adr are broadcast
    assign head               = fifo_dout[0];
    assign o_l2c_wb_ack_stall = fifo_empty || (head ? i_req1_ack_stall : i_req0_ack_stall);
    assign o_req0_ack_valid   = i_l2c_wb_ack_valid && !fifo_empty && !head;
    assign o_req1_ack_valid   = i_l2c_wb_ack_valid && !fifo_empty && head;
    assign o_req0_ack_fault   = i_l2c_wb_ack_fault;
    assign o_req1_ack_fault   = i_l2c_wb_ack_fault;
    assign o_req0_ack_adr     = i_l2c_wb_ack_adr;
    assign o_req1_ack_adr     = i_l2c_wb_ack_adr;
    assign pop                = i_l2c_wb_ack_valid && !o_l2c_wb_ack_stall;

endmodule
